// File: rtl/fsm_div_master.sv
// fsm_div_master: sends a dividend/divisor pair to the serial divider and returns its quotient.
// The result or a timeout is reported with a one-cycle done pulse.
module fsm_div_master #(
  parameter int TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] a_in,
  input  logic [3:0] b_in,
  output logic       busy,
  output logic       done,
  output logic [3:0] q_out,
  output logic       err_div,
  output logic       err_timeout,
  output logic       dv_valid,
  output logic [3:0] dv_data,
  input  logic       rs_valid,
  input  logic [3:0] rs_data,
  input  logic       rs_error
);
  typedef enum logic [2:0] {SYNC, IDLE, SEND_A, SEND_B, WAIT, DONE} state_t;
  localparam logic [7:0] LIMIT = 8'(TIMEOUT);
  state_t     r_state;
  logic [7:0] r_cnt;
  logic [3:0] r_b;
  // WAIT spans TIMEOUT+1 cycles, so the limit is reached when cnt equals TIMEOUT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= SYNC;
      r_cnt       <= '0;
      r_b         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      q_out       <= '0;
      err_div     <= 1'b0;
      err_timeout <= 1'b0;
      dv_valid    <= 1'b0;
      dv_data     <= '0;
    end else begin
      done     <= 1'b0;
      dv_valid <= 1'b0;
      dv_data  <= '0;
      case (r_state)
        SYNC:
          if (r_cnt == 8'd2) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            busy    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
            busy  <= 1'b1;
          end
        IDLE:
          if (start) begin
            r_b      <= b_in;
            dv_valid <= 1'b1;
            dv_data  <= a_in;
            busy     <= 1'b1;
            r_state  <= SEND_A;
          end
        SEND_A: begin
          dv_valid <= 1'b1;
          dv_data  <= r_b;
          r_state  <= SEND_B;
        end
        SEND_B: begin
          r_cnt   <= '0;
          r_state <= WAIT;
        end
        WAIT:
          if (rs_valid) begin
            q_out       <= rs_data;
            err_div     <= rs_error;
            err_timeout <= 1'b0;
            done        <= 1'b1;
            r_state     <= DONE;
          end else if (r_cnt == LIMIT) begin
            err_div     <= 1'b0;
            err_timeout <= 1'b1;
            done        <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        DONE: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= SYNC;
      endcase
    end
  end
endmodule

// File: tb/tb_fsm_div_master.sv
// tb_fsm_div_master: directed bench for fsm_div_master with a behavioural divider responder.
module tb_fsm_div_master;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] a_in = '0;
  logic [3:0] b_in = '0;
  logic       busy, done, err_div, err_timeout, dv_valid;
  logic [3:0] q_out, dv_data;
  logic       rs_valid, rs_error;
  logic [3:0] rs_data;
  logic       m_valid = 1'b0;
  logic       m_have = 1'b0;
  logic       m_error = 1'b0;
  logic [3:0] m_a = '0;
  logic [3:0] m_data = '0;
  logic       rs_force = 1'b0;
  int         m_wait = 0;
  int         dly = 2;
  int         checks = 0;
  int         errors = 0;
  int         ndone = 0;

  assign rs_valid = m_valid | rs_force;
  assign rs_data  = rs_force ? 4'hA : m_data;
  assign rs_error = rs_force ? 1'b1 : m_error;

  fsm_div_master #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .q_out(q_out), .err_div(err_div), .err_timeout(err_timeout),
    .dv_valid(dv_valid), .dv_data(dv_data),
    .rs_valid(rs_valid), .rs_data(rs_data), .rs_error(rs_error)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] div_ref(input logic [3:0] a, input logic [3:0] b);
    int qi;
    logic [31:0] t;
    if (b == 4'd0) return 5'b10000;
    qi = int'($signed(a)) / int'($signed(b));
    t = qi;
    return {1'b0, t[3:0]};
  endfunction

  // Divider responder: result pulse dly cycles after the divisor beat (dly 0 = never answers)
  always @(posedge clk) begin
    if (!reset) begin
      m_have  <= 1'b0;
      m_wait  <= 0;
      m_valid <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      if (m_wait > 0) begin
        m_wait <= m_wait - 1;
        if (m_wait == 1) m_valid <= 1'b1;
      end
      if (dv_valid) begin
        if (!m_have) begin
          m_have <= 1'b1;
          m_a    <= dv_data;
        end else begin
          m_have  <= 1'b0;
          m_wait  <= (dly > 0) ? dly - 1 : 0;
          {m_error, m_data} <= div_ref(m_a, dv_data);
        end
      end
    end
  end

  always @(negedge clk) if (done === 1'b1) ndone++;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic txn(input string tag, input logic [3:0] a, input logic [3:0] b, input int d,
                     input int lat, input logic [3:0] eq, input logic ed, input logic et);
    int n;
    @(negedge clk);
    dly = d;
    a_in = a;
    b_in = b;
    start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
    end while (done !== 1'b1 && n < 40);
    chk({tag, "_lat"}, 8'(n), 8'(lat));
    chk({tag, "_q"}, {4'h0, q_out}, {4'h0, eq});
    chk({tag, "_ediv"}, {7'h0, err_div}, {7'h0, ed});
    chk({tag, "_eto"}, {7'h0, err_timeout}, {7'h0, et});
  endtask

  initial begin
    int nd;
    start = 1'b1;
    a_in  = 4'd7;
    b_in  = 4'd2;
    repeat (3) @(negedge clk);
    chk("rst_busy", {7'h0, busy}, 8'h00);
    chk("rst_done", {7'h0, done}, 8'h00);
    chk("rst_q", {4'h0, q_out}, 8'h00);
    chk("rst_dv", {3'h0, dv_valid, dv_data}, 8'h00);
    chk("rst_err", {6'h0, err_div, err_timeout}, 8'h00);
    reset = 1'b1;
    @(negedge clk); chk("sync1_busy", {7'h0, busy}, 8'h01); chk("sync1_dv", {7'h0, dv_valid}, 8'h00);
    @(negedge clk); chk("sync2_busy", {7'h0, busy}, 8'h01); chk("sync2_dv", {7'h0, dv_valid}, 8'h00);
    @(negedge clk); chk("idle_busy", {7'h0, busy}, 8'h00); chk("idle_dv", {7'h0, dv_valid}, 8'h00);
    @(negedge clk); chk("senda", {3'h0, dv_valid, dv_data}, 8'h17);
    start = 1'b0;
    @(negedge clk); chk("sendb", {3'h0, dv_valid, dv_data}, 8'h12);
    @(negedge clk); chk("wait_dv", {3'h0, dv_valid, dv_data}, 8'h00); chk("c3_done", {7'h0, done}, 8'h00);
    @(negedge clk); chk("c4_done", {7'h0, done}, 8'h00);
    @(negedge clk); chk("c5_done", {7'h0, done}, 8'h01); chk("c5_q", {4'h0, q_out}, 8'h03);
    chk("c5_err", {6'h0, err_div, err_timeout}, 8'h00);
    @(negedge clk); chk("c6_done", {7'h0, done}, 8'h00); chk("c6_busy", {7'h0, busy}, 8'h00);

    txn("neg7_2", 4'b1001, 4'd2, 2, 5, 4'b1101, 1'b0, 1'b0);
    txn("div0", 4'd5, 4'd0, 2, 5, 4'd0, 1'b1, 1'b0);
    txn("wrap", 4'b1000, 4'b1111, 2, 5, 4'b1000, 1'b0, 1'b0);
    txn("edge_win", 4'd6, 4'd3, 9, 12, 4'd2, 1'b0, 1'b0);
    txn("late_to", 4'd1, 4'd1, 10, 12, 4'd2, 1'b0, 1'b1);
    txn("tiedoff", 4'd2, 4'd1, 0, 12, 4'd2, 1'b0, 1'b1);
    txn("clr_to", 4'd7, 4'b1110, 2, 5, 4'b1101, 1'b0, 1'b0);

    @(negedge clk);
    nd = ndone;
    dly = 2; a_in = 4'd1; b_in = 4'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; a_in = 4'd6;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("ign_done", {7'h0, done}, 8'h01);
    chk("ign_q", {4'h0, q_out}, 8'h01);
    repeat (10) @(negedge clk);
    chk("ign_count", 8'(ndone - nd), 8'h01);

    nd = ndone;
    rs_force = 1'b1;
    repeat (3) @(negedge clk);
    rs_force = 1'b0;
    chk("idle_rs_q", {4'h0, q_out}, 8'h01);
    chk("idle_rs_err", {6'h0, err_div, err_timeout}, 8'h00);
    chk("idle_rs_busy", {7'h0, busy}, 8'h00);
    chk("idle_rs_done", 8'(ndone - nd), 8'h00);

    dly = 0; a_in = 4'd3; b_in = 4'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_pre_busy", {7'h0, busy}, 8'h01);
    nd = ndone;
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", {7'h0, busy}, 8'h00);
    chk("abort_q", {4'h0, q_out}, 8'h00);
    chk("abort_out", {1'b0, done, err_div, err_timeout, dv_valid, dv_data != 4'd0}, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk); chk("resync1", {7'h0, busy}, 8'h01);
    @(negedge clk); chk("resync2", {7'h0, busy}, 8'h01);
    @(negedge clk); chk("reidle", {7'h0, busy}, 8'h00);
    chk("abort_nodone", 8'(ndone - nd), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
